core_io_responder: RTL
======================

Name: core_io_responder

Overview:
- Peripheral-side responder for the RISC_V_Core I/O port.
- Consumes core requests on to_peripheral/to_peripheral_data/to_peripheral_valid.
- Answers on from_peripheral/from_peripheral_data/from_peripheral_valid.
- Buffers data between the core and an external host through an RX FIFO (host to core) and a TX FIFO (core to host). Sits beside the core in the tile and in instruction/IO testbenches.

Parameters:
DATA_WIDTH, 32, width of request/response data and FIFO entries
FIFO_DEPTH, 8, entries per FIFO; must be a power of 2, range 2..256
CNT_BITS, clog2(FIFO_DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
to_peripheral  in  2  request opcode: 00 NOP, 01 WRITE, 10 READ, 11 STATUS
to_peripheral_data  in  DATA_WIDTH  WRITE payload
to_peripheral_valid  in  1  request strobe, one cycle per request
from_peripheral  out  2  response code: 00 NONE, 01 ACK/DATA, 10 NACK, 11 STATUS
from_peripheral_data  out  DATA_WIDTH  response payload
from_peripheral_valid  out  1  response strobe
host_rx_data  in  DATA_WIDTH  host word to core
host_rx_valid  in  1  host push request
host_rx_ready  out  1  RX FIFO can accept
host_tx_data  out  DATA_WIDTH  head of TX FIFO
host_tx_valid  out  1  TX FIFO not empty
host_tx_ready  in  1  host pops TX head

Behaviour:
- Reset (async assert, sync release): both FIFOs empty and pointers zero.
  - from_peripheral=00, from_peripheral_data=0, from_peripheral_valid=0.
  - host_tx_valid=0, host_tx_data=0, host_rx_ready=1.
- Request accepted only when to_peripheral_valid=1. Opcode 00 with valid produces no response and no state change.
- Response latency is exactly 1 cycle. Request sampled at edge N; response is registered and visible after edge N, valid for one cycle only. Back-to-back requests get back-to-back responses. There is no stall path.
- WRITE:
  - TX not full: push to_peripheral_data; respond 01, data = 0.
  - TX full: drop the word; respond 10, data = 0.
  - Exception: if the host pops TX in the same cycle while full, the push is accepted (ACK).
- READ:
  - RX not empty: pop the head; respond 01, data = head word.
  - RX empty: respond 10, data = 0.
  - Exception: a host push in the same cycle on an empty RX FIFO does NOT satisfy the read (NACK). The word becomes visible next cycle.
- STATUS: respond 11, data = {rx_count zero-extended to 16b, tx_count zero-extended to 16b}. Counts are sampled before the same-cycle push/pop takes effect.
- Host RX side:
  - Push when host_rx_valid && host_rx_ready.
  - host_rx_ready = !rx_full || core READ pop in the same cycle.
- Host TX side:
  - host_tx_data/host_tx_valid show the TX head combinationally from FIFO storage.
  - Pop when host_tx_valid && host_tx_ready.
- Occupancy:
  - Counters range 0..FIFO_DEPTH.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
  - Simultaneous push and pop leaves the count unchanged.
  - Full = (count == FIFO_DEPTH); empty = (count == 0).
- Reset mid-operation: in-flight response discarded, FIFO contents lost, outputs return to reset values immediately.
- Response FSM: RESP_IDLE to RESP_ACTIVE on any valid non-NOP request. RESP_ACTIVE to RESP_ACTIVE on a consecutive request, otherwise back to RESP_IDLE. from_peripheral_valid = (state == RESP_ACTIVE).

Decomposition:
- Shared package core_io_pkg holds:
  - Opcode constants: IO_NOP=2'b00, IO_WRITE=2'b01, IO_READ=2'b10, IO_STATUS=2'b11.
  - Response constants: RSP_NONE=00, RSP_ACK=01, RSP_NACK=10, RSP_STATUS=11.
  - Status field positions.
- One sub-module, io_sync_fifo (parameters DATA_WIDTH, FIFO_DEPTH), instantiated twice for RX and TX. It provides push/pop/full/empty/count/head. Push-when-full is allowed only with a simultaneous pop.
- The top level holds the request decode, response register and FSM.

Test Plan:
- Reset, then STATUS -> response 11, data 0x00000000 one cycle later; host_tx_valid=0, host_rx_ready=1.
- WRITE 0xDEADBEEF, then WRITE 0x12345678 -> two ACK(01) responses. host_tx_data=0xDEADBEEF, host_tx_valid=1. After two host pops, the second word is 0x12345678, then host_tx_valid=0.
- Host pushes 0xA5A5A5A5 and 0x5A5A5A5A, then READ, READ, READ -> 01/0xA5A5A5A5, then 01/0x5A5A5A5A, then 10/0x00000000.
- Fill TX with 8 WRITEs (0..7), then a 9th WRITE 0xFF -> NACK; STATUS = 0x00000008. Repeat the 9th WRITE with host_tx_ready=1 at full -> ACK; tx_count remains 8.
- RX empty, READ issued in the same cycle as host push of 0x11 -> NACK. Next READ -> 01/0x00000011.
- Write 3 words, assert reset asynchronously mid-clock -> outputs 0 immediately; after release, STATUS = 0x00000000 and host_tx_valid=0.

Source files
------------

// File: rtl/core_io_pkg.sv
// Shared opcode/response encodings, status word layout and response FSM state type
// for the core I/O responder.
package core_io_pkg;

    localparam logic [1:0] IO_NOP    = 2'b00;
    localparam logic [1:0] IO_WRITE  = 2'b01;
    localparam logic [1:0] IO_READ   = 2'b10;
    localparam logic [1:0] IO_STATUS = 2'b11;

    localparam logic [1:0] RSP_NONE   = 2'b00;
    localparam logic [1:0] RSP_ACK    = 2'b01;
    localparam logic [1:0] RSP_NACK   = 2'b10;
    localparam logic [1:0] RSP_STATUS = 2'b11;

    // STATUS word: rx_count in the upper half, tx_count in the lower half
    localparam int unsigned STATUS_TX_LSB  = 0;
    localparam int unsigned STATUS_RX_LSB  = 16;
    localparam int unsigned STATUS_FIELD_W = 16;

    typedef enum logic {
        RESP_IDLE   = 1'b0,
        RESP_ACTIVE = 1'b1
    } resp_state_e;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with occupancy counter; a push while full is taken only
// when a pop happens in the same cycle. Head reads as zero while empty.
module io_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic [DATA_WIDTH-1:0]       head
);

    localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 256) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0))
    begin : g_bad_depth
        $error("io_sync_fifo: FIFO_DEPTH must be a power of 2 in 2..256");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q;
    logic [PTR_BITS-1:0]   rd_ptr_q;
    logic [CNT_BITS-1:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == CNT_BITS'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; an empty FIFO never exposes it.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/core_io_responder.sv
// Peripheral-side responder for the core I/O port: decodes core requests, answers one
// cycle later, and bridges data to/from a host through RX and TX FIFOs.
module core_io_responder
    import core_io_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            to_peripheral,
    input  logic [DATA_WIDTH-1:0] to_peripheral_data,
    input  logic                  to_peripheral_valid,
    output logic [1:0]            from_peripheral,
    output logic [DATA_WIDTH-1:0] from_peripheral_data,
    output logic                  from_peripheral_valid,
    input  logic [DATA_WIDTH-1:0] host_rx_data,
    input  logic                  host_rx_valid,
    output logic                  host_rx_ready,
    output logic [DATA_WIDTH-1:0] host_tx_data,
    output logic                  host_tx_valid,
    input  logic                  host_tx_ready
);

    localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH) + 1;

    logic                  req_write;
    logic                  req_read;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_full;
    logic                  rx_empty;
    logic [CNT_BITS-1:0]   rx_count;
    logic [DATA_WIDTH-1:0] rx_head;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  tx_full;
    logic                  tx_empty;
    logic [CNT_BITS-1:0]   tx_count;
    logic [DATA_WIDTH-1:0] tx_head;
    logic [DATA_WIDTH-1:0] status_word;

    resp_state_e           state_q;
    resp_state_e           state_d;
    logic [1:0]            rsp_code_q;
    logic [1:0]            rsp_code_d;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [DATA_WIDTH-1:0] rsp_data_d;

    assign req_write = to_peripheral_valid && (to_peripheral == IO_WRITE);
    assign req_read  = to_peripheral_valid && (to_peripheral == IO_READ);

    assign tx_pop  = !tx_empty && host_tx_ready;
    assign tx_push = req_write && (!tx_full || tx_pop);

    // A read on an empty RX FIFO is never satisfied by a same-cycle host push.
    assign rx_pop        = req_read && !rx_empty;
    assign host_rx_ready = !rx_full || rx_pop;
    assign rx_push       = host_rx_valid && host_rx_ready;

    assign host_tx_data  = tx_head;
    assign host_tx_valid = !tx_empty;

    io_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (host_rx_data),
        .pop       (rx_pop),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count),
        .head      (rx_head)
    );

    io_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (to_peripheral_data),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .head      (tx_head)
    );

    always_comb begin
        status_word = '0;
        status_word[STATUS_RX_LSB +: CNT_BITS] = rx_count;
        status_word[STATUS_TX_LSB +: CNT_BITS] = tx_count;
    end

    always_comb begin
        state_d    = RESP_IDLE;
        rsp_code_d = RSP_NONE;
        rsp_data_d = '0;
        if (to_peripheral_valid && (to_peripheral != IO_NOP)) begin
            state_d = RESP_ACTIVE;
            unique case (to_peripheral)
                IO_WRITE: begin
                    rsp_code_d = tx_push ? RSP_ACK : RSP_NACK;
                end
                IO_READ: begin
                    if (rx_pop) begin
                        rsp_code_d = RSP_ACK;
                        rsp_data_d = rx_head;
                    end else begin
                        rsp_code_d = RSP_NACK;
                    end
                end
                IO_STATUS: begin
                    rsp_code_d = RSP_STATUS;
                    rsp_data_d = status_word;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RESP_IDLE;
            rsp_code_q <= RSP_NONE;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rsp_code_q <= rsp_code_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign from_peripheral       = rsp_code_q;
    assign from_peripheral_data  = rsp_data_q;
    assign from_peripheral_valid = (state_q == RESP_ACTIVE);

endmodule
